// File: rtl/player_pkg.sv
// Shared definitions for the player mover: direction codes, screen defaults,
// player size and the key-repeat FSM state encoding.
package player_pkg;

   // Direction codes carried on the 4-bit button bus
   localparam logic [3:0] BTN_UP    = 4'd8;
   localparam logic [3:0] BTN_DOWN  = 4'd4;
   localparam logic [3:0] BTN_RIGHT = 4'd2;
   localparam logic [3:0] BTN_LEFT  = 4'd1;

   // Screen and player geometry defaults
   localparam int unsigned DEF_H_RES       = 640;
   localparam int unsigned DEF_V_RES       = 480;
   localparam int unsigned DEF_PLAYER_SIZE = 12;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESS,
      ST_DELAY,
      ST_REPEAT
   } state_t;

   // True when the button bus carries exactly one of the four direction codes
   function automatic logic is_dir(input logic [3:0] b);
      return (b == BTN_UP) || (b == BTN_DOWN) || (b == BTN_RIGHT) || (b == BTN_LEFT);
   endfunction

endpackage

// File: rtl/key_repeat.sv
// Press-then-auto-repeat sequencer for the direction buttons.
// Ports:
//   clk, rst_n : tick clock, async active-low reset
//   btns       : raw direction code
//   dir        : latched direction code of the current press
//   move_c     : combinational strobe, high on ticks that attempt a move
//   moving     : high whenever the FSM is not idle
module key_repeat
   import player_pkg::*;
#(
   parameter int unsigned REPEAT_DLY  = 8,
   parameter int unsigned REPEAT_RATE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] btns,
   output logic [3:0] dir,
   output logic       move_c,
   output logic       moving
);

   localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);

   state_t             state, state_next;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic [3:0]         dir_next;

   // State, counter and latched direction registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         dir    <= '0;
         moving <= 1'b0;
      end else begin
         state  <= state_next;
         cnt    <= cnt_next;
         dir    <= dir_next;
         moving <= (state_next != ST_IDLE);
      end
   end

   // Next-state and move strobe; any change of the held code drops back to idle
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      dir_next   = dir;
      move_c     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (is_dir(btns)) begin
               dir_next   = btns;
               state_next = ST_PRESS;
            end
         end
         ST_PRESS: begin
            move_c     = 1'b1;
            cnt_next   = '0;
            state_next = ST_DELAY;
         end
         ST_DELAY: begin
            if (btns != dir) begin
               state_next = ST_IDLE;
            end else if (cnt == CNT_W'(REPEAT_DLY - 1)) begin
               move_c     = 1'b1;
               cnt_next   = '0;
               state_next = ST_REPEAT;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         ST_REPEAT: begin
            if (btns != dir) begin
               state_next = ST_IDLE;
            end else if (cnt == CNT_W'(REPEAT_RATE - 1)) begin
               move_c   = 1'b1;
               cnt_next = '0;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/player_mover.sv
// Moves a square player one pixel per attempt under rectangle and screen-edge
// permission, with press-then-auto-repeat timing, and cycles the player colour.
// Ports:
//   btnClk, rst      : tick clock, async active-low reset
//   btns             : direction code (8 up, 4 down, 2 right, 1 left)
//   colorBtn         : level input, each rising edge advances the colour
//   up/down/left/rightEnable : per-rectangle movement permissions
//   player_hPos/vPos : player left / top edge
//   player_color     : current colour index
//   moving           : FSM not idle
//   blocked          : one-tick pulse on a refused move attempt
module player_mover
   import player_pkg::*;
#(
   parameter int unsigned N_RECT      = 4,
   parameter int unsigned PLAYER_SIZE = DEF_PLAYER_SIZE,
   parameter int unsigned H_RES       = DEF_H_RES,
   parameter int unsigned V_RES       = DEF_V_RES,
   parameter int unsigned H_START     = 314,
   parameter int unsigned V_START     = 0,
   parameter int unsigned REPEAT_DLY  = 8,
   parameter int unsigned REPEAT_RATE = 2,
   parameter int unsigned N_COLORS    = 4
) (
   input  logic              btnClk,
   input  logic              rst,
   input  logic [3:0]        btns,
   input  logic              colorBtn,
   input  logic [N_RECT-1:0] upEnable,
   input  logic [N_RECT-1:0] downEnable,
   input  logic [N_RECT-1:0] leftEnable,
   input  logic [N_RECT-1:0] rightEnable,
   output logic [31:0]       player_hPos,
   output logic [31:0]       player_vPos,
   output logic [3:0]        player_color,
   output logic              moving,
   output logic              blocked
);

   logic [3:0] dir;
   logic       move_c;
   logic       permit_c;
   logic       color_hist;

   key_repeat #(
      .REPEAT_DLY  (REPEAT_DLY),
      .REPEAT_RATE (REPEAT_RATE)
   ) u_key_repeat (
      .clk    (btnClk),
      .rst_n  (rst),
      .btns   (btns),
      .dir    (dir),
      .move_c (move_c),
      .moving (moving)
   );

   // Permission: every rectangle agrees and the step stays on screen (no underflow)
   always_comb begin
      permit_c = 1'b0;
      case (dir)
         BTN_UP:    permit_c = (&upEnable)    && (player_vPos > 32'd0);
         BTN_DOWN:  permit_c = (&downEnable)  && ((player_vPos + 32'(PLAYER_SIZE)) < 32'(V_RES));
         BTN_LEFT:  permit_c = (&leftEnable)  && (player_hPos > 32'd0);
         BTN_RIGHT: permit_c = (&rightEnable) && ((player_hPos + 32'(PLAYER_SIZE)) < 32'(H_RES));
         default:   permit_c = 1'b0;
      endcase
   end

   // Position registers and refused-move pulse
   always_ff @(posedge btnClk or negedge rst) begin
      if (!rst) begin
         player_hPos <= 32'(H_START);
         player_vPos <= 32'(V_START);
         blocked     <= 1'b0;
      end else begin
         blocked <= move_c && !permit_c;
         if (move_c && permit_c) begin
            case (dir)
               BTN_UP:    player_vPos <= player_vPos - 32'd1;
               BTN_DOWN:  player_vPos <= player_vPos + 32'd1;
               BTN_LEFT:  player_hPos <= player_hPos - 32'd1;
               BTN_RIGHT: player_hPos <= player_hPos + 32'd1;
               default:   ;
            endcase
         end
      end
   end

   // Colour advances on each rising edge of the registered colour button
   always_ff @(posedge btnClk or negedge rst) begin
      if (!rst) begin
         color_hist   <= 1'b0;
         player_color <= '0;
      end else begin
         color_hist <= colorBtn;
         if (colorBtn && !color_hist) begin
            player_color <= (player_color == 4'(N_COLORS - 1)) ? 4'd0 : player_color + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_player_mover.sv
// Scoreboard bench for player_mover: stimulus pushes expected outputs tagged
// with the clock edge they belong to; a monitor compares them at the falling edge.
module tb_player_mover;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  btns;
   logic        color_btn;
   logic [3:0]  up_en, down_en, left_en, right_en;
   logic [31:0] hpos, vpos;
   logic [3:0]  color;
   logic        moving, blocked;

   always #5 clk = ~clk;

   player_mover dut (
      .btnClk       (clk),
      .rst          (rst_n),
      .btns         (btns),
      .colorBtn     (color_btn),
      .upEnable     (up_en),
      .downEnable   (down_en),
      .leftEnable   (left_en),
      .rightEnable  (right_en),
      .player_hPos  (hpos),
      .player_vPos  (vpos),
      .player_color (color),
      .moving       (moving),
      .blocked      (blocked)
   );

   typedef struct {
      int unsigned cyc;
      string       name;
      logic [31:0] h;
      logic [31:0] v;
      logic [3:0]  c;
      logic        m;
      logic        b;
   } exp_t;

   exp_t        q[$];
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] eh, ev;
   logic [3:0]  ec;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation registered for the current edge
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         e = q.pop_front();
         n_checks++;
         if (e.cyc < cyc) begin
            $display("FAIL %s: expectation for edge %0d was never compared", e.name, e.cyc);
         end else if (hpos === e.h && vpos === e.v && color === e.c &&
                      moving === e.m && blocked === e.b) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got h=%0d v=%0d c=%0d m=%b b=%b, expected h=%0d v=%0d c=%0d m=%b b=%b",
                     e.name, hpos, vpos, color, moving, blocked, e.h, e.v, e.c, e.m, e.b);
         end
      end
   end

   task automatic push(input string name, input logic m, input logic b);
      exp_t e;
      e.cyc  = cyc;
      e.name = name;
      e.h    = eh;
      e.v    = ev;
      e.c    = ec;
      e.m    = m;
      e.b    = b;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Moves happen on hold edge 2, then every 2nd edge from edge 10
   function automatic bit is_move_edge(input int k);
      return (k == 2) || (k >= 10 && (k % 2) == 0);
   endfunction

   task automatic apply_move(input logic [3:0] code);
      case (code)
         4'd8: ev = ev - 32'd1;
         4'd4: ev = ev + 32'd1;
         4'd2: eh = eh + 32'd1;
         4'd1: eh = eh - 32'd1;
         default: ;
      endcase
   endtask

   // One press: IDLE->PRESS edge, move edge, release edge back to IDLE
   task automatic pulse(input logic [3:0] code, input logic ok, input bit chk, input string name);
      btns = code;
      tick();
      if (chk) push({name, "_press"}, 1'b1, 1'b0);
      tick();
      if (ok) apply_move(code);
      if (chk) push({name, "_move"}, 1'b1, !ok);
      btns = 4'd0;
      tick();
      if (chk) push({name, "_idle"}, 1'b0, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; btns = 4'd0; color_btn = 1'b0;
      up_en = 4'hF; down_en = 4'hF; left_en = 4'hF; right_en = 4'hF;
      eh = 32'd314; ev = 32'd0; ec = 4'd0;

      repeat (2) tick();
      push("reset", 1'b0, 1'b0);
      rst_n = 1'b1;
      tick();
      push("post_reset_idle", 1'b0, 1'b0);

      // Hold down for 21 edges
      btns = 4'd4;
      for (int k = 1; k <= 21; k++) begin
         tick();
         if (is_move_edge(k)) ev = ev + 32'd1;
         push($sformatf("hold_down_e%0d", k), 1'b1, 1'b0);
      end
      btns = 4'd0;
      tick();
      push("hold_release", 1'b0, 1'b0);

      // Asynchronous reset in the middle of auto-repeat
      btns = 4'd4;
      for (int k = 1; k <= 12; k++) tick();
      #3;
      rst_n = 1'b0;
      eh = 32'd314; ev = 32'd0; ec = 4'd0;
      push("async_reset_mid_repeat", 1'b0, 1'b0);
      btns = 4'd0;
      tick();
      rst_n = 1'b1;
      tick();
      push("after_async_reset", 1'b0, 1'b0);

      // Top edge clamp straight out of reset
      pulse(4'd8, 1'b0, 1'b1, "top_edge");

      // Rectangle permission gating
      repeat (5) pulse(4'd4, 1'b1, 1'b0, "");
      down_en = 4'b1101;
      pulse(4'd4, 1'b0, 1'b1, "down_en_refused");
      down_en = 4'hF;
      pulse(4'd4, 1'b1, 1'b1, "down_en_allowed");

      // Direction change from down to up during auto-repeat
      btns = 4'd4;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (is_move_edge(k)) ev = ev + 32'd1;
      end
      push("repeat_before_switch", 1'b1, 1'b0);
      btns = 4'd8;
      tick();
      push("switch_idle", 1'b0, 1'b0);
      tick();
      push("switch_press", 1'b1, 1'b0);
      tick();
      ev = ev - 32'd1;
      push("switch_up_move", 1'b1, 1'b0);
      btns = 4'd0;
      tick();
      push("switch_release", 1'b0, 1'b0);

      // Invalid codes never leave idle
      btns = 4'd3;
      repeat (3) tick();
      push("invalid_3", 1'b0, 1'b0);
      btns = 4'd12;
      repeat (3) tick();
      push("invalid_12", 1'b0, 1'b0);
      btns = 4'd0;

      // Screen edge clamps
      while (eh != 32'd0) pulse(4'd1, 1'b1, 1'b0, "");
      pulse(4'd1, 1'b0, 1'b1, "left_edge");
      while (eh != 32'd628) pulse(4'd2, 1'b1, 1'b0, "");
      pulse(4'd2, 1'b0, 1'b1, "right_edge");
      while (ev != 32'd468) pulse(4'd4, 1'b1, 1'b0, "");
      pulse(4'd4, 1'b0, 1'b1, "bottom_edge");
      while (ev != 32'd0) pulse(4'd8, 1'b1, 1'b0, "");

      // Colour: a long press advances once, then pulses wrap 2,3,0
      color_btn = 1'b1;
      tick();
      ec = 4'd1;
      push("color_rise", 1'b0, 1'b0);
      repeat (9) tick();
      push("color_held", 1'b0, 1'b0);
      color_btn = 1'b0;
      tick();
      push("color_release", 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         color_btn = 1'b1;
         tick();
         ec = (i == 0) ? 4'd2 : (i == 1) ? 4'd3 : 4'd0;
         push($sformatf("color_pulse%0d", i), 1'b0, 1'b0);
         color_btn = 1'b0;
         tick();
      end

      // Colour change on the same edge as a move
      btns = 4'd1;
      tick();
      color_btn = 1'b1;
      tick();
      eh = eh - 32'd1;
      ec = 4'd1;
      push("color_with_move", 1'b1, 1'b0);
      btns = 4'd0;
      color_btn = 1'b0;
      tick();
      push("color_with_move_idle", 1'b0, 1'b0);

      repeat (3) tick();
      if (q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
